// File: rtl/syn_fft_twdl_ram_ctrl_if.sv
// Host local-bus and FFT-engine fetch signals of the twiddle RAM controller.
// The RAM controller itself uses the slave view. The host/engine side (or a
// testbench standing in for both) uses the master view.
interface syn_fft_twdl_ram_ctrl_if #(
    parameter int P_TWDL_W    = 10,
    parameter int P_ADDR_W    = 7,
    parameter int P_LB_DATA_W = 32
);
    // Host local bus
    logic                     lb_wr_en_i;
    logic                     lb_rd_en_i;
    logic [P_ADDR_W-1:0]      lb_addr_i;
    logic [P_LB_DATA_W-1:0]   lb_wr_data_i;
    logic                     lb_rd_valid_o;
    logic [P_LB_DATA_W-1:0]   lb_rd_data_o;
    logic                     lb_err_o;

    // Butterfly engine fetch port
    logic                     twdl_rd_en_i;
    logic [P_ADDR_W:0]        twdl_idx_i;
    logic                     twdl_rd_valid_o;
    logic [2*P_TWDL_W-1:0]    twdl_o;

    modport slave (
        input  lb_wr_en_i, lb_rd_en_i, lb_addr_i, lb_wr_data_i,
        input  twdl_rd_en_i, twdl_idx_i,
        output lb_rd_valid_o, lb_rd_data_o, lb_err_o,
        output twdl_rd_valid_o, twdl_o
    );

    modport master (
        output lb_wr_en_i, lb_rd_en_i, lb_addr_i, lb_wr_data_i,
        output twdl_rd_en_i, twdl_idx_i,
        input  lb_rd_valid_o, lb_rd_data_o, lb_err_o,
        input  twdl_rd_valid_o, twdl_o
    );
endinterface

// File: rtl/syn_fft_twdl_ram_ctrl.sv
// Twiddle-factor RAM controller for fgyrus.
// CONFIG mode lets the host load and read back the table. NORMAL mode serves
// the FFT engine, which fetches {re,im} entries. For indices in the upper half
// of the range, the entry is rotated by -j. A mode FSM drains the shared
// two-stage read pipeline before the owner of the RAM changes.
module syn_fft_twdl_ram_ctrl #(
    parameter int P_TWDL_W    = 10,
    parameter int P_ADDR_W    = 7,
    parameter int P_LB_DATA_W = 32
) (
    input  logic                    clk_ir,
    input  logic                    rst_il,
    input  logic                    fgyrus_mode_i,
    output logic                    fgyrus_mode_o,
    syn_fft_twdl_ram_ctrl_if.slave  bus
);

    localparam int   DEPTH       = 2**P_ADDR_W;
    localparam int   ENT_W       = 2*P_TWDL_W;
    localparam int   RE_LSB      = 16;
    localparam logic MODE_NORMAL = 1'b0;
    localparam logic MODE_CONFIG = 1'b1;

    typedef enum logic [1:0] {
        NORMAL_S = 2'd0,
        CFG_S    = 2'd1,
        DRAIN_S  = 2'd2
    } state_t;

    // Saturating two's-complement negation: the most negative code maps to
    // the most positive one instead of wrapping onto itself.
    function automatic logic signed [P_TWDL_W-1:0] neg_sat(
        input logic signed [P_TWDL_W-1:0] v
    );
        logic signed [P_TWDL_W-1:0] min_v;
        logic signed [P_TWDL_W-1:0] max_v;
        min_v = {1'b1, {(P_TWDL_W-1){1'b0}}};
        max_v = {1'b0, {(P_TWDL_W-1){1'b1}}};
        if (v == min_v) begin
            return max_v;
        end
        return -v;
    endfunction

    // Multiply a stored {re,im} entry by -j when rot is set: (re + j*im)*(-j) = im - j*re.
    function automatic logic [ENT_W-1:0] rot_mj(
        input logic [ENT_W-1:0] ent,
        input logic             rot
    );
        logic signed [P_TWDL_W-1:0] re;
        logic signed [P_TWDL_W-1:0] im;
        re = ent[ENT_W-1:P_TWDL_W];
        im = ent[P_TWDL_W-1:0];
        if (rot) begin
            return {im, neg_sat(re)};
        end
        return {re, im};
    endfunction

    // Host readback packing: re at [RE_LSB +: W], im at [0 +: W], everything else zero.
    function automatic logic [P_LB_DATA_W-1:0] pack_lb(input logic [ENT_W-1:0] ent);
        logic [P_LB_DATA_W-1:0] w;
        w = '0;
        w[RE_LSB +: P_TWDL_W] = ent[ENT_W-1:P_TWDL_W];
        w[0 +: P_TWDL_W]      = ent[P_TWDL_W-1:0];
        return w;
    endfunction

    // Reset synchroniser: asserts asynchronously, releases on a clock edge.
    logic rst_meta_q;
    logic rst_n_q;

    // Two-flop release of the internal reset.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Mode FSM state
    state_t state_q;
    logic   mode_q;
    logic   tgt_q;

    // Storage and read pipeline
    logic [ENT_W-1:0]       mem_q [DEPTH];
    logic [ENT_W-1:0]       ram_rd_p1_q;
    logic                   msb_p1_q,      msb_p1_d;
    logic                   eng_vld_p1_q,  eng_vld_p1_d;
    logic                   host_vld_p1_q, host_vld_p1_d;
    logic                   eng_vld_p2_q,  eng_vld_p2_d;
    logic                   host_vld_p2_q, host_vld_p2_d;
    logic                   lb_err_q,      lb_err_d;
    logic [ENT_W-1:0]       twdl_q,        twdl_d;
    logic [P_LB_DATA_W-1:0] lb_rd_data_q,  lb_rd_data_d;

    // Request decode
    logic                   host_cfg;
    logic                   eng_ok;
    logic                   mem_we;
    logic                   host_rd_acc;
    logic                   eng_rd_acc;
    logic                   rd_fire;
    logic [P_ADDR_W-1:0]    rd_addr;
    logic [ENT_W-1:0]       wr_entry;
    logic                   pipe_empty;
    logic                   wr_data_unused;

    // Decide which end owns the RAM this cycle and which strobes are honoured.
    always_comb begin
        host_cfg    = (state_q == CFG_S);
        eng_ok      = (state_q == NORMAL_S);
        mem_we      = host_cfg & bus.lb_wr_en_i;
        host_rd_acc = host_cfg & bus.lb_rd_en_i & ~bus.lb_wr_en_i;
        eng_rd_acc  = eng_ok & bus.twdl_rd_en_i;
        rd_fire     = host_rd_acc | eng_rd_acc;
        rd_addr     = host_cfg ? bus.lb_addr_i : bus.twdl_idx_i[P_ADDR_W-1:0];
        wr_entry    = {bus.lb_wr_data_i[RE_LSB +: P_TWDL_W], bus.lb_wr_data_i[0 +: P_TWDL_W]};
        pipe_empty  = ~(eng_vld_p1_q | eng_vld_p2_q | host_vld_p1_q | host_vld_p2_q);
        // Rejected: any strobe outside CFG_S, or a read colliding with a write.
        lb_err_d    = (bus.lb_wr_en_i | bus.lb_rd_en_i)
                    & (~host_cfg | (bus.lb_wr_en_i & bus.lb_rd_en_i));
    end

    // Only the documented re/im fields of the write word are stored.
    assign wr_data_unused = ^bus.lb_wr_data_i;

    // Next-state values of the read pipeline and of the held outputs.
    always_comb begin
        // stage 0 -> 1: accepted request, RAM address issued
        eng_vld_p1_d  = eng_rd_acc;
        host_vld_p1_d = host_rd_acc;
        msb_p1_d      = eng_rd_acc ? bus.twdl_idx_i[P_ADDR_W] : msb_p1_q;
        // stage 1 -> 2: RAM data formatted into the output registers
        eng_vld_p2_d  = eng_vld_p1_q;
        host_vld_p2_d = host_vld_p1_q;
        twdl_d        = twdl_q;
        lb_rd_data_d  = lb_rd_data_q;
        if (eng_vld_p1_q) begin
            twdl_d = rot_mj(ram_rd_p1_q, msb_p1_q);
        end
        if (host_vld_p1_q) begin
            lb_rd_data_d = pack_lb(ram_rd_p1_q);
        end
    end

    // Mode FSM: on a mode request, drain the read pipeline, then hand the RAM over.
    always_ff @(posedge clk_ir or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q <= NORMAL_S;
            mode_q  <= MODE_NORMAL;
            tgt_q   <= MODE_NORMAL;
        end else begin
            case (state_q)
                NORMAL_S, CFG_S: begin
                    if (fgyrus_mode_i != mode_q) begin
                        tgt_q   <= fgyrus_mode_i;
                        state_q <= DRAIN_S;
                    end
                end
                DRAIN_S: begin
                    if (pipe_empty) begin
                        state_q <= (tgt_q == MODE_CONFIG) ? CFG_S : NORMAL_S;
                        mode_q  <= tgt_q;
                    end
                end
                default: begin
                    state_q <= NORMAL_S;
                    mode_q  <= MODE_NORMAL;
                end
            endcase
        end
    end

    // Twiddle storage with one write port and one registered read port (stage 1 data).
    always_ff @(posedge clk_ir) begin
        if (mem_we) begin
            mem_q[bus.lb_addr_i] <= wr_entry;
        end
        if (rd_fire) begin
            ram_rd_p1_q <= mem_q[rd_addr];
        end
        msb_p1_q <= msb_p1_d;
    end

    // Valid/error flags and the output registers, which are cleared on reset.
    always_ff @(posedge clk_ir or negedge rst_n_q) begin
        if (!rst_n_q) begin
            eng_vld_p1_q  <= 1'b0;
            host_vld_p1_q <= 1'b0;
            eng_vld_p2_q  <= 1'b0;
            host_vld_p2_q <= 1'b0;
            lb_err_q      <= 1'b0;
            twdl_q        <= '0;
            lb_rd_data_q  <= '0;
        end else begin
            eng_vld_p1_q  <= eng_vld_p1_d;
            host_vld_p1_q <= host_vld_p1_d;
            eng_vld_p2_q  <= eng_vld_p2_d;
            host_vld_p2_q <= host_vld_p2_d;
            lb_err_q      <= lb_err_d;
            twdl_q        <= twdl_d;
            lb_rd_data_q  <= lb_rd_data_d;
        end
    end

    assign fgyrus_mode_o       = mode_q;
    assign bus.lb_rd_valid_o   = host_vld_p2_q;
    assign bus.lb_rd_data_o    = lb_rd_data_q;
    assign bus.lb_err_o        = lb_err_q;
    assign bus.twdl_rd_valid_o = eng_vld_p2_q;
    assign bus.twdl_o          = twdl_q;

endmodule
